control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port i_clk, input, 1, single system clock; all state changes on rising edge.
REQ-002 SHALL have port i_nReset, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port i_instrData, input, 8, instruction or immediate byte.
REQ-004 SHALL have port i_instrValid, input, 1, i_instrData valid.
REQ-005 SHALL have port o_instrReady, output, 1, sequencer accepts a byte this cycle.
REQ-006 SHALL have port i_aluFlagN, input, 1, datapath ALU negative flag.
REQ-007 SHALL have port i_aluFlagZ, input, 1, datapath ALU zero flag.
REQ-008 SHALL have ports o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluShiftLeft, o_ctrlRegWr0, o_ctrlRegWr1, o_ctrlRegBusSel, o_ctrlRegBusEn, o_ctrlAluSel, all output, 1 bit each, datapath controls.
REQ-009 SHALL have port o_ctrlAluOp, output, 2, ALU operation select.
REQ-010 SHALL have port o_busOverride, output, 8, immediate driven to datapath bus.
REQ-011 SHALL have port o_busOverrideEn, output, 1, o_busOverride valid; when 0, o_busOverride = 8'h00.
REQ-012 SHALL have port o_branchTaken, output, 1, one-cycle pulse on taken branch.
REQ-013 SHALL have port o_illegal, output, 1, one-cycle pulse on undefined opcode.
REQ-014 SHALL have port o_instrCount, output, 16, retired-instruction counter.

Function
REQ-015 SHALL implement states FETCH, DECODE, IMM, EXEC.
REQ-016 FETCH: o_instrReady=1; on i_instrValid=1, SHALL latch i_instrData into the instruction register and go to DECODE; otherwise stay in FETCH.
REQ-017 DECODE: SHALL last exactly 1 cycle, with all control outputs 0; opcode = instr[7:5].
REQ-018 Opcode 001 LDI (dst = instr[0]): DECODE -> IMM; IMM behaves as FETCH but latches the immediate, then -> EXEC; EXEC drives o_busOverride=imm, o_busOverrideEn=1, o_ctrlRegWr{dst}=1 for 1 cycle.
REQ-019 Opcode 010 ALU: EXEC drives o_ctrlAluOE=1, o_ctrlAluOp=instr[4:3], o_ctrlAluSub=instr[2], o_ctrlAluShiftLeft=instr[0], o_ctrlAluSel=0, o_ctrlRegWr{instr[1]}=1 for 1 cycle; at the end of EXEC SHALL latch i_aluFlagN/Z into internal flags.
REQ-020 Opcode 011 MOV (src = instr[0]): EXEC drives o_ctrlRegBusEn=1, o_ctrlRegBusSel=src, o_ctrlRegWr{~src}=1 for 1 cycle.
REQ-021 Opcode 100 BR (cond = instr[1:0]; 00 Z, 01 N, 10 !Z, 11 always): evaluated on latched flags; EXEC asserts o_branchTaken=1 iff cond true; no other controls.
REQ-022 Opcode 000 NOP: EXEC with all controls 0.
REQ-023 Opcodes 101/110/111: SHALL pulse o_illegal in the cycle after DECODE, return to FETCH, and not increment o_instrCount.
REQ-024 EXEC SHALL always be 1 cycle, then -> FETCH; o_instrCount SHALL increment by 1 at the end of every EXEC and wrap 16'hFFFF -> 16'h0000.
REQ-025 Latency: 1-byte instruction = FETCH(handshake) + DECODE + EXEC = 3 cycles minimum; LDI = 4 cycles minimum.
REQ-026 o_instrReady SHALL be 0 in DECODE and EXEC; i_instrValid in those states SHALL be ignored (byte is held by the source).
REQ-027 All control outputs SHALL be registered, glitch-free, and 0 outside EXEC.
REQ-028 o_ctrlRegWr0 and o_ctrlRegWr1 SHALL never be 1 in the same cycle.

Reset
REQ-029 While i_nReset=0 at a rising edge: state=FETCH, instruction/immediate registers=0, flags=0, o_instrCount=0, all control, pulse and override outputs=0, o_instrReady=0.
REQ-030 Reset asserted in any state SHALL abort the instruction without retiring it; o_instrReady SHALL be 1 in the first cycle after release.

Verification
REQ-031 LDI r0: bytes 8'h20, 8'h2A -> EXEC cycle o_busOverride=8'h2A, o_busOverrideEn=1, o_ctrlRegWr0=1; o_instrCount=1.
REQ-032 ALU sub into r1 (8'h46), bench sets i_aluFlagZ=1 in EXEC, then BR Z (8'h80) -> o_ctrlAluOE=1, o_ctrlAluSub=1, o_ctrlRegWr1=1; o_branchTaken pulses 1 cycle.
REQ-033 BR !Z (8'h82) after the same flags -> o_branchTaken stays 0; o_instrCount still increments.
REQ-034 Byte 8'hE0 -> o_illegal pulses once, o_instrCount unchanged, back in FETCH.
REQ-035 i_nReset=0 during IMM of an LDI -> no write strobe, o_instrCount=0, FETCH with o_instrReady=1 after release.
REQ-036 65536 NOPs -> o_instrCount wraps to 16'h0000.

Source files
------------

// File: rtl/control_sequencer.sv
// Byte-serial control sequencer: fetches 1- or 2-byte instructions and issues one
// cycle of registered datapath control strobes per retired instruction.
module control_sequencer (
    input  logic        i_clk,
    input  logic        i_nReset,
    input  logic [7:0]  i_instrData,
    input  logic        i_instrValid,
    output logic        o_instrReady,
    input  logic        i_aluFlagN,
    input  logic        i_aluFlagZ,
    output logic        o_ctrlAluOE,
    output logic        o_ctrlAluSub,
    output logic        o_ctrlAluShiftLeft,
    output logic        o_ctrlRegWr0,
    output logic        o_ctrlRegWr1,
    output logic        o_ctrlRegBusSel,
    output logic        o_ctrlRegBusEn,
    output logic        o_ctrlAluSel,
    output logic [1:0]  o_ctrlAluOp,
    output logic [7:0]  o_busOverride,
    output logic        o_busOverrideEn,
    output logic        o_branchTaken,
    output logic        o_illegal,
    output logic [15:0] o_instrCount
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        IMM    = 2'd2,
        EXEC   = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_ALU = 3'b010;
    localparam logic [2:0] OP_MOV = 3'b011;
    localparam logic [2:0] OP_BR  = 3'b100;

    state_t      state_r;
    state_t      stateNext_s;
    logic [7:0]  instrReg_r;
    logic [2:0]  opcode_s;
    logic        flagN_r;
    logic        flagZ_r;
    logic [15:0] instrCount_r;

    logic        aluOE_s,    aluOE_r;
    logic        aluSub_s,   aluSub_r;
    logic        aluShl_s,   aluShl_r;
    logic        regWr0_s,   regWr0_r;
    logic        regWr1_s,   regWr1_r;
    logic        busSel_s,   busSel_r;
    logic        busEn_s,    busEn_r;
    logic        aluSel_s,   aluSel_r;
    logic [1:0]  aluOp_s,    aluOp_r;
    logic [7:0]  override_s, override_r;
    logic        ovrEn_s,    ovrEn_r;
    logic        branch_s,   branch_r;
    logic        illegal_s,  illegal_r;

    // Branch condition evaluated against the flags captured by the last ALU op.
    function automatic logic branchCond(input logic [1:0] cond, input logic flagN, input logic flagZ);
        logic taken;
        case (cond)
            2'b00:   taken = flagZ;
            2'b01:   taken = flagN;
            2'b10:   taken = ~flagZ;
            2'b11:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    assign opcode_s = instrReg_r[7:5];

    // Ready is a pure state decode, gated by reset so it is low while reset is held.
    assign o_instrReady = i_nReset & ((state_r == FETCH) | (state_r == IMM));

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_nReset) begin
            state_r <= FETCH;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next-state decode.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            FETCH: begin
                if (i_instrValid) begin
                    stateNext_s = DECODE;
                end else begin
                    stateNext_s = FETCH;
                end
            end
            DECODE: begin
                case (opcode_s)
                    OP_LDI:  stateNext_s = IMM;
                    OP_NOP:  stateNext_s = EXEC;
                    OP_ALU:  stateNext_s = EXEC;
                    OP_MOV:  stateNext_s = EXEC;
                    OP_BR:   stateNext_s = EXEC;
                    default: stateNext_s = FETCH;
                endcase
            end
            IMM: begin
                if (i_instrValid) begin
                    stateNext_s = EXEC;
                end else begin
                    stateNext_s = IMM;
                end
            end
            EXEC:    stateNext_s = FETCH;
            default: stateNext_s = FETCH;
        endcase
    end

    // Output decode: computes the strobes for the coming cycle so they can be registered.
    always_comb begin
        aluOE_s    = 1'b0;
        aluSub_s   = 1'b0;
        aluShl_s   = 1'b0;
        regWr0_s   = 1'b0;
        regWr1_s   = 1'b0;
        busSel_s   = 1'b0;
        busEn_s    = 1'b0;
        aluSel_s   = 1'b0;
        aluOp_s    = 2'b00;
        override_s = 8'h00;
        ovrEn_s    = 1'b0;
        branch_s   = 1'b0;
        illegal_s  = 1'b0;
        case (state_r)
            DECODE: begin
                case (opcode_s)
                    OP_ALU: begin
                        aluOE_s  = 1'b1;
                        aluOp_s  = instrReg_r[4:3];
                        aluSub_s = instrReg_r[2];
                        aluShl_s = instrReg_r[0];
                        aluSel_s = 1'b0;
                        regWr0_s = ~instrReg_r[1];
                        regWr1_s = instrReg_r[1];
                    end
                    OP_MOV: begin
                        busEn_s  = 1'b1;
                        busSel_s = instrReg_r[0];
                        regWr0_s = instrReg_r[0];
                        regWr1_s = ~instrReg_r[0];
                    end
                    OP_BR: begin
                        branch_s = branchCond(instrReg_r[1:0], flagN_r, flagZ_r);
                    end
                    OP_NOP: begin
                        illegal_s = 1'b0;
                    end
                    OP_LDI: begin
                        illegal_s = 1'b0;
                    end
                    default: begin
                        illegal_s = 1'b1;
                    end
                endcase
            end
            IMM: begin
                // The immediate goes straight into the override register as it is accepted.
                if (i_instrValid) begin
                    override_s = i_instrData;
                    ovrEn_s    = 1'b1;
                    regWr0_s   = ~instrReg_r[0];
                    regWr1_s   = instrReg_r[0];
                end else begin
                    ovrEn_s    = 1'b0;
                end
            end
            default: begin
                ovrEn_s = 1'b0;
            end
        endcase
    end

    // Registered control, pulse and override outputs.
    always_ff @(posedge i_clk) begin
        if (!i_nReset) begin
            aluOE_r    <= 1'b0;
            aluSub_r   <= 1'b0;
            aluShl_r   <= 1'b0;
            regWr0_r   <= 1'b0;
            regWr1_r   <= 1'b0;
            busSel_r   <= 1'b0;
            busEn_r    <= 1'b0;
            aluSel_r   <= 1'b0;
            aluOp_r    <= 2'b00;
            override_r <= 8'h00;
            ovrEn_r    <= 1'b0;
            branch_r   <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            aluOE_r    <= aluOE_s;
            aluSub_r   <= aluSub_s;
            aluShl_r   <= aluShl_s;
            regWr0_r   <= regWr0_s;
            regWr1_r   <= regWr1_s;
            busSel_r   <= busSel_s;
            busEn_r    <= busEn_s;
            aluSel_r   <= aluSel_s;
            aluOp_r    <= aluOp_s;
            override_r <= override_s;
            ovrEn_r    <= ovrEn_s;
            branch_r   <= branch_s;
            illegal_r  <= illegal_s;
        end
    end

    // Instruction register, captured ALU flags and retired-instruction counter.
    always_ff @(posedge i_clk) begin
        if (!i_nReset) begin
            instrReg_r   <= 8'h00;
            flagN_r      <= 1'b0;
            flagZ_r      <= 1'b0;
            instrCount_r <= 16'h0000;
        end else begin
            if ((state_r == FETCH) && i_instrValid) begin
                instrReg_r <= i_instrData;
            end
            if (state_r == EXEC) begin
                instrCount_r <= instrCount_r + 16'd1;
                if (opcode_s == OP_ALU) begin
                    flagN_r <= i_aluFlagN;
                    flagZ_r <= i_aluFlagZ;
                end
            end
        end
    end

    assign o_ctrlAluOE        = aluOE_r;
    assign o_ctrlAluSub       = aluSub_r;
    assign o_ctrlAluShiftLeft = aluShl_r;
    assign o_ctrlRegWr0       = regWr0_r;
    assign o_ctrlRegWr1       = regWr1_r;
    assign o_ctrlRegBusSel    = busSel_r;
    assign o_ctrlRegBusEn     = busEn_r;
    assign o_ctrlAluSel       = aluSel_r;
    assign o_ctrlAluOp        = aluOp_r;
    assign o_busOverride      = override_r;
    assign o_busOverrideEn    = ovrEn_r;
    assign o_branchTaken      = branch_r;
    assign o_illegal          = illegal_r;
    assign o_instrCount       = instrCount_r;

    control_sequencer_checker u_checker (
        .i_clk    (i_clk),
        .i_nReset (i_nReset),
        .state    (state_r),
        .regWr0   (regWr0_r),
        .regWr1   (regWr1_r),
        .ctrlAny  (aluOE_r | aluSub_r | aluShl_r | regWr0_r | regWr1_r | busSel_r | busEn_r |
                   aluSel_r | (|aluOp_r) | ovrEn_r | branch_r),
        .illegal  (illegal_r)
    );

endmodule

// Structural invariants of the sequencer outputs.
module control_sequencer_checker (
    input logic       i_clk,
    input logic       i_nReset,
    input logic [1:0] state,
    input logic       regWr0,
    input logic       regWr1,
    input logic       ctrlAny,
    input logic       illegal
);

    // Never write both registers at once.
    assert property (@(posedge i_clk) disable iff (!i_nReset) !(regWr0 && regWr1))
        else $error("both register write strobes active");

    // Datapath strobes only appear in the execute state.
    assert property (@(posedge i_clk) disable iff (!i_nReset) (state != 2'd3) |-> !ctrlAny)
        else $error("control strobe outside execute");

    // Illegal-opcode indication is a single-cycle pulse.
    assert property (@(posedge i_clk) disable iff (!i_nReset) illegal |=> !illegal)
        else $error("illegal pulse longer than one cycle");

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
module tb_control_sequencer;

    logic        i_clk;
    logic        i_nReset;
    logic [7:0]  i_instrData;
    logic        i_instrValid;
    logic        o_instrReady;
    logic        i_aluFlagN;
    logic        i_aluFlagZ;
    logic        o_ctrlAluOE;
    logic        o_ctrlAluSub;
    logic        o_ctrlAluShiftLeft;
    logic        o_ctrlRegWr0;
    logic        o_ctrlRegWr1;
    logic        o_ctrlRegBusSel;
    logic        o_ctrlRegBusEn;
    logic        o_ctrlAluSel;
    logic [1:0]  o_ctrlAluOp;
    logic [7:0]  o_busOverride;
    logic        o_busOverrideEn;
    logic        o_branchTaken;
    logic        o_illegal;
    logic [15:0] o_instrCount;

    int vectorCount = 0;
    int missCount   = 0;
    logic [15:0] expCount = 16'h0000;

    // [12]aluOE [11]sub [10]shl [9]wr0 [8]wr1 [7]busSel [6]busEn [5]aluSel [4:3]aluOp [2]ovrEn [1]branch [0]illegal
    logic [12:0] ctrlVec;
    assign ctrlVec = {o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluShiftLeft, o_ctrlRegWr0, o_ctrlRegWr1,
                      o_ctrlRegBusSel, o_ctrlRegBusEn, o_ctrlAluSel, o_ctrlAluOp,
                      o_busOverrideEn, o_branchTaken, o_illegal};

    localparam logic [12:0] C_NONE   = 13'b0_0_0_0_0_0_0_0_00_0_0_0;
    localparam logic [12:0] C_LDI0   = 13'b0_0_0_1_0_0_0_0_00_1_0_0;
    localparam logic [12:0] C_LDI1   = 13'b0_0_0_0_1_0_0_0_00_1_0_0;
    localparam logic [12:0] C_SUBR1  = 13'b1_1_0_0_1_0_0_0_00_0_0_0;
    localparam logic [12:0] C_OP3SHL = 13'b1_0_1_0_1_0_0_0_11_0_0_0;
    localparam logic [12:0] C_MOV10  = 13'b0_0_0_1_0_1_1_0_00_0_0_0;
    localparam logic [12:0] C_MOV01  = 13'b0_0_0_0_1_0_1_0_00_0_0_0;
    localparam logic [12:0] C_BRANCH = 13'b0_0_0_0_0_0_0_0_00_0_1_0;
    localparam logic [12:0] C_ILL    = 13'b0_0_0_0_0_0_0_0_00_0_0_1;

    control_sequencer dut (
        .i_clk              (i_clk),
        .i_nReset           (i_nReset),
        .i_instrData        (i_instrData),
        .i_instrValid       (i_instrValid),
        .o_instrReady       (o_instrReady),
        .i_aluFlagN         (i_aluFlagN),
        .i_aluFlagZ         (i_aluFlagZ),
        .o_ctrlAluOE        (o_ctrlAluOE),
        .o_ctrlAluSub       (o_ctrlAluSub),
        .o_ctrlAluShiftLeft (o_ctrlAluShiftLeft),
        .o_ctrlRegWr0       (o_ctrlRegWr0),
        .o_ctrlRegWr1       (o_ctrlRegWr1),
        .o_ctrlRegBusSel    (o_ctrlRegBusSel),
        .o_ctrlRegBusEn     (o_ctrlRegBusEn),
        .o_ctrlAluSel       (o_ctrlAluSel),
        .o_ctrlAluOp        (o_ctrlAluOp),
        .o_busOverride      (o_busOverride),
        .o_busOverrideEn    (o_busOverrideEn),
        .o_branchTaken      (o_branchTaken),
        .o_illegal          (o_illegal),
        .o_instrCount       (o_instrCount)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        i_instrData  = b;
        i_instrValid = 1'b1;
        tick();
        i_instrValid = 1'b0;
    endtask

    // One-byte instruction: DECODE, then EXEC with the given flags presented, then FETCH.
    task automatic runOne(input string tag, input logic [7:0] b, input logic [12:0] expCtrl,
                          input logic flagN, input logic flagZ);
        checkValue({tag, "_ready"}, 32'(o_instrReady), 32'd1);
        sendByte(b);
        checkValue({tag, "_decode"}, {18'd0, o_instrReady, ctrlVec}, 32'd0);
        i_aluFlagN = flagN;
        i_aluFlagZ = flagZ;
        tick();
        checkValue({tag, "_exec"}, {19'd0, ctrlVec}, {19'd0, expCtrl});
        tick();
        i_aluFlagN = ~flagN;
        i_aluFlagZ = ~flagZ;
        expCount = expCount + 16'd1;
        checkValue({tag, "_count"}, {16'd0, o_instrCount}, {16'd0, expCount});
        checkValue({tag, "_after"}, {19'd0, ctrlVec}, 32'd0);
    endtask

    // LDI with the immediate presented (and held) from the DECODE cycle onward.
    task automatic runLdi(input string tag, input logic [7:0] op, input logic [7:0] imm,
                          input logic [12:0] expCtrl);
        sendByte(op);
        checkValue({tag, "_decode_ready"}, 32'(o_instrReady), 32'd0);
        i_instrData  = imm;
        i_instrValid = 1'b1;
        tick();
        checkValue({tag, "_imm_ready"}, 32'(o_instrReady), 32'd1);
        checkValue({tag, "_imm_ctrl"}, {19'd0, ctrlVec}, 32'd0);
        tick();
        i_instrValid = 1'b0;
        checkValue({tag, "_exec"}, {19'd0, ctrlVec}, {19'd0, expCtrl});
        checkValue({tag, "_bus"}, {24'd0, o_busOverride}, {24'd0, imm});
        tick();
        expCount = expCount + 16'd1;
        checkValue({tag, "_count"}, {16'd0, o_instrCount}, {16'd0, expCount});
        checkValue({tag, "_bus_idle"}, {23'd0, o_busOverrideEn, o_busOverride}, 32'd0);
    endtask

    task automatic runIllegal(input string tag, input logic [7:0] b);
        sendByte(b);
        tick();
        checkValue({tag, "_pulse"}, {19'd0, ctrlVec}, {19'd0, C_ILL});
        checkValue({tag, "_fetch"}, 32'(o_instrReady), 32'd1);
        checkValue({tag, "_count"}, {16'd0, o_instrCount}, {16'd0, expCount});
        tick();
        checkValue({tag, "_once"}, 32'(o_illegal), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_nReset     = 1'b0;
        i_instrData  = 8'h00;
        i_instrValid = 1'b0;
        i_aluFlagN   = 1'b0;
        i_aluFlagZ   = 1'b0;
        tick();
        tick();
        checkValue("rst_ready", 32'(o_instrReady), 32'd0);
        checkValue("rst_ctrl", {19'd0, ctrlVec}, 32'd0);
        checkValue("rst_out", {8'd0, o_busOverride, o_instrCount}, 32'd0);
        i_nReset = 1'b1;
        #1;
        checkValue("rel_ready", 32'(o_instrReady), 32'd1);

        runLdi("ldi_r0", 8'h20, 8'h2A, C_LDI0);
        runLdi("ldi_r1", 8'h21, 8'h5C, C_LDI1);

        // flags captured as Z=1,N=0; live inputs are inverted afterwards
        runOne("alu_sub", 8'h46, C_SUBR1, 1'b0, 1'b1);
        runOne("br_z",    8'h80, C_BRANCH, 1'b0, 1'b0);
        runOne("br_nz",   8'h82, C_NONE,   1'b1, 1'b0);
        runOne("br_n0",   8'h81, C_NONE,   1'b1, 1'b1);
        // flags captured as N=1,Z=0
        runOne("alu_op3", 8'h5B, C_OP3SHL, 1'b1, 1'b0);
        runOne("br_n1",   8'h81, C_BRANCH, 1'b0, 1'b1);
        runOne("br_z0",   8'h80, C_NONE,   1'b0, 1'b1);
        runOne("br_nz1",  8'h82, C_BRANCH, 1'b0, 1'b1);
        runOne("br_al",   8'h83, C_BRANCH, 1'b0, 1'b0);
        runOne("mov_1to0", 8'h61, C_MOV10, 1'b0, 1'b0);
        runOne("mov_0to1", 8'h60, C_MOV01, 1'b0, 1'b0);
        runOne("nop",     8'h00, C_NONE,   1'b1, 1'b1);

        runIllegal("ill_e0", 8'hE0);
        runIllegal("ill_a0", 8'hA0);

        // reset while waiting for an LDI immediate, with the immediate on offer
        sendByte(8'h20);
        tick();
        i_instrData  = 8'h99;
        i_instrValid = 1'b1;
        i_nReset     = 1'b0;
        tick();
        i_instrValid = 1'b0;
        checkValue("rstimm_ctrl", {19'd0, ctrlVec}, 32'd0);
        checkValue("rstimm_count", {16'd0, o_instrCount}, 32'd0);
        checkValue("rstimm_ready_low", 32'(o_instrReady), 32'd0);
        i_nReset = 1'b1;
        #1;
        checkValue("rstimm_ready", 32'(o_instrReady), 32'd1);
        tick();
        checkValue("rstimm_nowrite", {19'd0, ctrlVec}, 32'd0);
        checkValue("rstimm_count2", {16'd0, o_instrCount}, 32'd0);
        expCount = 16'h0000;
        runOne("nop_post", 8'h00, C_NONE, 1'b0, 1'b0);

        // Preload the counter near the top so the wrap needs two NOPs, not 65536.
        force dut.instrCount_r = 16'hFFFE;
        #2;
        release dut.instrCount_r;
        expCount = 16'hFFFE;
        runOne("nop_ffff", 8'h00, C_NONE, 1'b0, 1'b0);
        runOne("nop_wrap", 8'h00, C_NONE, 1'b0, 1'b0);
        checkValue("wrap_zero", {16'd0, o_instrCount}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
